// File: rtl/cmac_tx_axis_pkt_mux.sv
// cmac_tx_axis_pkt_mux: store-and-forward AXIS packet mux feeding CMAC TX.
// Whole packets are buffered per channel; round-robin grant at packet edges.
module cmac_tx_axis_pkt_mux #(
  parameter int DATA_W     = 512,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tx_enable,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH*DATA_W/8-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  input  logic [NUM_CH-1:0]        s_axis_tuser,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [DATA_W/8-1:0]      m_axis_tkeep,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  input  logic                     m_axis_tready,
  input  logic                     tx_ovfout,
  input  logic                     tx_unfout,
  output logic [CNT_W-1:0]         pkt_sent_cnt,
  output logic [CNT_W-1:0]         pkt_drop_cnt,
  output logic                     ovf_err,
  output logic                     unf_err,
  output logic                     busy
);
  localparam int KW = DATA_W / 8;
  localparam int EW = DATA_W + KW + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [EW-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [AW:0] wr_ptr [NUM_CH];
  logic [AW:0] wr_commit [NUM_CH];
  logic [AW:0] rd_ptr [NUM_CH];
  logic [AW:0] pkt_cnt [NUM_CH];
  logic [NUM_CH-1:0] drop;

  logic [NUM_CH-1:0] acc, ovs, drop_ev, pend;
  logic [GW-1:0] last_grant, grant_nxt, rr_pick, rr_idx;
  logic [EW-1:0] rd_word;
  logic rd_last, rd_adv;
  logic [3:0] drop_num;
  logic [CNT_W:0] drop_sum;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_axis_tready[i] = !reset &&
        (drop[i] || (wr_ptr[i] - rd_ptr[i]) != FULL);
      acc[i] = s_axis_tvalid[i] && s_axis_tready[i] && !drop[i];
      drop_ev[i] = drop[i] && s_axis_tvalid[i] && s_axis_tlast[i];
      ovs[i] = !drop[i] && (wr_ptr[i] - wr_commit[i]) == FULL;
      pend[i] = pkt_cnt[i] != '0;
      drop_num = drop_num + 4'(drop_ev[i]);
    end
    drop_sum = {1'b0, pkt_drop_cnt} + (CNT_W+1)'(drop_num);
  end

  assign rd_word = mem[last_grant][rd_ptr[last_grant][AW-1:0]];
  assign rd_last = rd_word[1];
  assign rd_adv  = (state == SEND) && m_axis_tready;

  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = m_axis_tvalid ? rd_word[EW-1 -: DATA_W] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? rd_word[KW+1:2] : '0;
  assign m_axis_tlast  = m_axis_tvalid && rd_last;
  assign m_axis_tuser  = m_axis_tvalid && rd_last && rd_word[0];
  assign busy          = (state == SEND) || (|pend);

  // Search downward so the nearest channel after last_grant wins.
  always_comb begin
    rr_pick = last_grant;
    rr_idx  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      rr_idx = GW'((int'(last_grant) + k) % NUM_CH);
      if (pend[rr_idx]) rr_pick = rr_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (tx_enable && (|pend)) begin
          state_nxt = SEND;
          grant_nxt = rr_pick;
        end
      end
      SEND: begin
        if (m_axis_tready && rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc[i])
        mem[i][wr_ptr[i][AW-1:0]] <= {s_axis_tdata[i*DATA_W +: DATA_W],
                                      s_axis_tkeep[i*KW +: KW],
                                      s_axis_tlast[i], s_axis_tuser[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= GW'(NUM_CH - 1);
      pkt_sent_cnt <= '0;
      pkt_drop_cnt <= '0;
      ovf_err      <= 1'b0;
      unf_err      <= 1'b0;
      drop         <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i]    <= '0;
        wr_commit[i] <= '0;
        rd_ptr[i]    <= '0;
        pkt_cnt[i]   <= '0;
      end
    end else begin
      state      <= state_nxt;
      last_grant <= grant_nxt;
      if (tx_ovfout) ovf_err <= 1'b1;
      if (tx_unfout) unf_err <= 1'b1;
      if (rd_adv && rd_last && pkt_sent_cnt != '1)
        pkt_sent_cnt <= pkt_sent_cnt + CNT_W'(1);
      pkt_drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (ovs[i]) begin
          wr_ptr[i] <= wr_commit[i];
          drop[i]   <= 1'b1;
        end else if (acc[i]) begin
          wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
          if (s_axis_tlast[i]) wr_commit[i] <= wr_ptr[i] + (AW+1)'(1);
        end
        if (drop_ev[i]) drop[i] <= 1'b0;
        if (rd_adv && last_grant == GW'(i))
          rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
        if ((acc[i] && s_axis_tlast[i]) &&
            !(rd_adv && rd_last && last_grant == GW'(i)))
          pkt_cnt[i] <= pkt_cnt[i] + (AW+1)'(1);
        else if (!(acc[i] && s_axis_tlast[i]) &&
                 (rd_adv && rd_last && last_grant == GW'(i)))
          pkt_cnt[i] <= pkt_cnt[i] - (AW+1)'(1);
      end
    end
  end
endmodule

// File: doc/cmac_tx_axis_pkt_mux.md
Name: cmac_tx_axis_pkt_mux

Overview:
N-channel store-and-forward AXI4-Stream packet multiplexer that feeds the CMAC TX AXIS port from several packet sources (ERNIC TX stream, test packet generator, further sources) on the CMAC user TX clock. Each channel buffers whole packets, so a packet is never started toward the CMAC until it is complete. This removes tx_unfout risk from bursty sources. Round-robin arbitration runs at packet boundaries. Oversize packets are dropped, and sent/dropped packets and CMAC overflow/underflow are reported.

Parameters:
DATA_W, 512, AXIS data width in bits (multiple of 8)
NUM_CH, 2, number of input channels (1..8)
FIFO_DEPTH, 64, beats per channel buffer (power of 2, >=4); also the maximum packet length in beats
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  CMAC user TX clock (gt_txusrclk2 domain)
reset  in  1  synchronous active-high reset (driven from usr_tx_reset)
tx_enable  in  1  arbitration enable (ctl_tx_enable && rx_aligned)
s_axis_tdata  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
s_axis_tkeep  in  NUM_CH*DATA_W/8  per-channel byte enables
s_axis_tvalid  in  NUM_CH  per-channel valid
s_axis_tlast  in  NUM_CH  per-channel end of packet
s_axis_tuser  in  NUM_CH  per-channel error flag (meaningful on tlast beat)
s_axis_tready  out  NUM_CH  per-channel ready
m_axis_tdata  out  DATA_W  to CMAC tx_axis_tdata
m_axis_tkeep  out  DATA_W/8  to CMAC tx_axis_tkeep
m_axis_tvalid  out  1  to CMAC tx_axis_tvalid
m_axis_tlast  out  1  to CMAC tx_axis_tlast
m_axis_tuser  out  1  to CMAC tx_axis_tuser
m_axis_tready  in  1  from CMAC tx_axis_tready
tx_ovfout  in  1  CMAC overflow pulse
tx_unfout  in  1  CMAC underflow pulse
pkt_sent_cnt  out  CNT_W  packets completed on m_axis
pkt_drop_cnt  out  CNT_W  oversize packets discarded (all channels)
ovf_err  out  1  sticky; set by tx_ovfout
unf_err  out  1  sticky; set by tx_unfout
busy  out  1  high when in SEND state or any channel holds a committed packet

Behaviour:
- Reset: all outputs 0, including s_axis_tready and counters. All buffers are flushed (rd/wr/commit pointers = 0, pkt_cnt = 0). Arbiter goes to IDLE with last_grant = NUM_CH-1, so channel 0 has first priority. Reset mid-packet discards all partial and buffered data with no counter increments.
- Ingress per channel i: circular buffer of {tdata,tkeep,tlast,tuser}.
  - Pointers: wr_ptr, wr_commit, rd_ptr; each has log2(FIFO_DEPTH)+1 bits and wraps naturally.
  - Normal mode: s_axis_tready[i] = (wr_ptr - rd_ptr) != FIFO_DEPTH. An accepted beat writes at wr_ptr and increments wr_ptr.
  - A tlast beat accepted in cycle N sets wr_commit = wr_ptr+1 and increments pkt_cnt[i]; both are visible in cycle N+1.
  - Oversize: when (wr_ptr - wr_commit) reaches FIFO_DEPTH without tlast, wr_ptr is rewound to wr_commit next cycle and the channel enters DROP.
  - DROP mode: s_axis_tready[i] = 1 and beats are discarded. The discarded tlast beat increments pkt_drop_cnt and returns the channel to normal. A packet of exactly FIFO_DEPTH beats is legal and is not dropped.
  - The reader never reads beyond wr_commit.
- pkt_cnt[i]: a write-commit and a read-tlast on the same channel in the same cycle leave it unchanged.
- Arbiter FSM:
  - IDLE: if tx_enable and any pkt_cnt > 0, grant the first channel with pkt_cnt > 0 searching from last_grant+1 (wrapping). Update last_grant and go to SEND. m_axis_tvalid rises the following cycle.
  - SEND: m_axis_tvalid is held 1 from first to last beat with no bubbles. Data advances only on m_axis_tready.
  - On tlast && tready: increment pkt_sent_cnt and return to IDLE. m_axis_tvalid is 0 for at least one cycle between packets.
  - tx_enable low blocks new grants only; a packet in progress always completes.
- Latency: tlast written in cycle N, with the arbiter idle and tx_enable high → first beat has m_axis_tvalid = 1 in cycle N+2.
- m_axis_tuser = stored tuser on the tlast beat, 0 on all other beats. Output fields are 0 whenever tvalid = 0.
- Counters saturate at all-ones. ovf_err and unf_err are cleared only by reset.

Test Plan:
- Single channel, one 9-beat packet (last tkeep = 64'h0000_0000_0000_03FF), m_axis_tready = 1 → 9 contiguous beats starting 2 cycles after s tlast, identical data/keep; pkt_sent_cnt = 1.
- NUM_CH = 2, both channels continuously loaded with 4-beat packets → output alternates ch0, ch1, ch0, ch1 with a 1-cycle gap between packets; after 10 packets pkt_sent_cnt = 10.
- Random m_axis_tready backpressure (50%) during a 16-beat packet → tvalid never drops mid-packet; data order is preserved; no beat is lost or duplicated.
- FIFO_DEPTH = 8: send a 9-beat packet on ch0, followed by a 3-beat packet → the 9-beat packet is dropped, pkt_drop_cnt = 1, only the 3-beat packet appears; an 8-beat packet passes intact.
- tx_enable = 0 while two packets are buffered → no output and busy = 1. Raise tx_enable → both are sent. Drop tx_enable mid-packet → the current packet completes and no new grant is made.
- Pulse tx_unfout for 1 cycle, then reset mid-packet → unf_err = 1 until reset. After reset, all outputs and counters are 0 and the partial packet is never emitted.
